// File: rtl/usb_cs_multi.sv
// USB link control-session controller.
// Send side: hand a packet to the tx engine, wait for the peer's answer, and
// retransmit on NAK or on a silent answer window, up to MAX_RETRY attempts.
// Read side: accept a packet from the rx engine, pick the RAM slot for its data,
// and auto-answer with ACK / NAK / STL.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | post-reset, moves straight to WAIT
// WAIT      | idle between sessions; send request has priority over rx
// SEND_PREP | latch packet type, start a fresh send session
// SEND_DATA | tx engine busy with our packet (fs_tx high)
// RANS_WAIT | answer window, timer counting
// RANS_TAKE | classify the answer and pick the follow-up state
// RANS_DONE | ack the answer to the rx engine (fd_rx high)
// SEND_DONE | report outcome to producer (fd_send high)
// READ_PREP | select rx RAM slot from data_idx
// READ_DATA | ack incoming packet to rx engine (fd_rx high)
// WANS_PREP | latch received type, choose the auto-answer
// WANS_DONE | tx engine sending the answer (fs_tx high)
// READ_DONE | hand received packet to consumer (fs_read high)
module usb_cs_multi #(
    parameter int TIMEOUT   = 128,
    parameter int MAX_RETRY = 16,
    parameter int NUM_SLOT  = 6,
    parameter int SLOT_SIZE = 'h240,
    parameter int ADDR_W    = 12,
    parameter int INIT_ADDR = 'hF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs_send,
    output logic              fd_send,
    input  logic [3:0]        send_btype,
    output logic [1:0]        send_status,
    output logic [7:0]        retry_cnt,
    output logic              fs_read,
    input  logic              fd_read,
    output logic [3:0]        read_btype,
    input  logic [3:0]        data_idx,
    output logic              fs_tx,
    input  logic              fd_tx,
    output logic [3:0]        tx_btype,
    input  logic              fs_rx,
    output logic              fd_rx,
    input  logic [3:0]        rx_btype,
    output logic [ADDR_W-1:0] rx_ram_init
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_IDLE = ADDR_W'(INIT_ADDR);

    localparam logic [3:0] BT_ACK = 4'h1;
    localparam logic [3:0] BT_NAK = 4'h2;
    localparam logic [3:0] BT_STL = 4'h3;
    localparam logic [3:0] BT_ERR = 4'hF;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_ACK  = 2'b01;
    localparam logic [1:0] ST_EXH  = 2'b10;
    localparam logic [1:0] ST_STL  = 2'b11;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WAIT      = 4'd1,
        SEND_PREP = 4'd2,
        SEND_DATA = 4'd3,
        RANS_WAIT = 4'd4,
        RANS_TAKE = 4'd5,
        RANS_DONE = 4'd6,
        SEND_DONE = 4'd7,
        READ_PREP = 4'd8,
        READ_DATA = 4'd9,
        WANS_PREP = 4'd10,
        WANS_DONE = 4'd11,
        READ_DONE = 4'd12
    } state_t;

    state_t            state, state_n;
    state_t            goto_q, goto_n;
    logic [3:0]        tx_btype_n, read_btype_n;
    logic [1:0]        send_status_n;
    logic [7:0]        retry_cnt_n, nak_cnt, nak_cnt_n;
    logic [ADDR_W-1:0] rx_ram_init_n;
    logic [TW-1:0]     timer, timer_n;
    logic              idx_ok, idx_ok_n;
    logic              may_retry;
    logic              slot_valid;
    logic [ADDR_W-1:0] slot_base;

    // retry counter saturates at its maximum value instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign may_retry  = 32'(retry_cnt) < 32'(MAX_RETRY);
    assign slot_valid = 32'(data_idx) < 32'(NUM_SLOT);
    assign slot_base  = ADDR_W'(32'(data_idx) * 32'(SLOT_SIZE));

    assign fd_send = (state == SEND_DONE);
    assign fs_read = (state == READ_DONE);
    assign fs_tx   = (state == SEND_DATA) || (state == WANS_DONE);
    assign fd_rx   = (state == RANS_DONE) || (state == READ_DATA);

    // state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            goto_q      <= IDLE;
            tx_btype    <= 4'h0;
            read_btype  <= 4'h0;
            send_status <= ST_NONE;
            retry_cnt   <= 8'd0;
            nak_cnt     <= 8'd0;
            rx_ram_init <= ADDR_IDLE;
            timer       <= '0;
            idx_ok      <= 1'b0;
        end else begin
            state       <= state_n;
            goto_q      <= goto_n;
            tx_btype    <= tx_btype_n;
            read_btype  <= read_btype_n;
            send_status <= send_status_n;
            retry_cnt   <= retry_cnt_n;
            nak_cnt     <= nak_cnt_n;
            rx_ram_init <= rx_ram_init_n;
            timer       <= timer_n;
            idx_ok      <= idx_ok_n;
        end
    end

    // next-state and next-datapath decode
    always_comb begin
        state_n       = state;
        goto_n        = goto_q;
        tx_btype_n    = tx_btype;
        read_btype_n  = read_btype;
        send_status_n = send_status;
        retry_cnt_n   = retry_cnt;
        nak_cnt_n     = nak_cnt;
        rx_ram_init_n = rx_ram_init;
        timer_n       = timer;
        idx_ok_n      = idx_ok;

        case (state)
            IDLE: state_n = WAIT;
            WAIT: begin
                retry_cnt_n   = 8'd0;
                tx_btype_n    = 4'h0;
                rx_ram_init_n = ADDR_IDLE;
                if (fs_send)    state_n = SEND_PREP;
                else if (fs_rx) state_n = READ_PREP;
            end
            SEND_PREP: begin
                tx_btype_n    = send_btype;
                send_status_n = ST_NONE;
                retry_cnt_n   = 8'd1;
                state_n       = SEND_DATA;
            end
            SEND_DATA: begin
                timer_n = '0;
                if (fd_tx) state_n = RANS_WAIT;
            end
            RANS_WAIT: begin
                timer_n = timer + TW'(1);
                // an answer arriving on the last window cycle still counts
                if (fs_rx) begin
                    state_n = RANS_TAKE;
                end else if (timer == TIMER_LAST) begin
                    if (may_retry) begin
                        retry_cnt_n = sat_inc(retry_cnt);
                        state_n     = SEND_DATA;
                    end else begin
                        send_status_n = ST_EXH;
                        state_n       = SEND_DONE;
                    end
                end
            end
            RANS_TAKE: begin
                state_n = RANS_DONE;
                if (rx_btype == BT_ACK) begin
                    goto_n        = SEND_DONE;
                    send_status_n = ST_ACK;
                end else if (rx_btype == BT_STL) begin
                    goto_n        = SEND_DONE;
                    send_status_n = ST_STL;
                end else if (may_retry) begin
                    goto_n      = SEND_DATA;
                    retry_cnt_n = sat_inc(retry_cnt);
                end else begin
                    goto_n        = SEND_DONE;
                    send_status_n = ST_EXH;
                end
            end
            RANS_DONE: if (!fs_rx) state_n = goto_q;
            SEND_DONE: if (!fs_send) state_n = WAIT;
            READ_PREP: begin
                idx_ok_n      = slot_valid;
                rx_ram_init_n = slot_valid ? slot_base : ADDR_IDLE;
                state_n       = READ_DATA;
            end
            READ_DATA: if (!fs_rx) state_n = WANS_PREP;
            WANS_PREP: begin
                read_btype_n = rx_btype;
                state_n      = WANS_DONE;
                if (!idx_ok) begin
                    tx_btype_n = BT_STL;
                end else if ((rx_btype == BT_ERR) &&
                             (32'(nak_cnt) < 32'(MAX_RETRY - 1))) begin
                    tx_btype_n = BT_NAK;
                    nak_cnt_n  = nak_cnt + 8'd1;
                end else begin
                    tx_btype_n = BT_ACK;
                    nak_cnt_n  = 8'd0;
                end
            end
            WANS_DONE: if (fd_tx) state_n = READ_DONE;
            READ_DONE: if (fd_read) state_n = WAIT;
            default:   state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb_cs_multi.sv
// Bench for usb_cs_multi: drives producer/consumer and tx/rx engine sides,
// predicts every observable event from a session-level model and checks it
// in a separate monitor through an expected-event queue.
module tb_usb_cs_multi;

    localparam int TIMEOUT   = 12;
    localparam int MAX_RETRY = 4;
    localparam int NUM_SLOT  = 6;
    localparam int SLOT_SIZE = 'h240;
    localparam int ADDR_W    = 12;
    localparam int INIT_ADDR = 'hF00;

    localparam int K_TX   = 0;
    localparam int K_DONE = 1;
    localparam int K_READ = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fs_send = 1'b0;
    logic              fd_send;
    logic [3:0]        send_btype = 4'h0;
    logic [1:0]        send_status;
    logic [7:0]        retry_cnt;
    logic              fs_read;
    logic              fd_read = 1'b0;
    logic [3:0]        read_btype;
    logic [3:0]        data_idx = 4'h0;
    logic              fs_tx;
    logic              fd_tx = 1'b0;
    logic [3:0]        tx_btype;
    logic              fs_rx = 1'b0;
    logic              fd_rx;
    logic [3:0]        rx_btype = 4'h0;
    logic [ADDR_W-1:0] rx_ram_init;

    usb_cs_multi #(
        .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .NUM_SLOT(NUM_SLOT),
        .SLOT_SIZE(SLOT_SIZE), .ADDR_W(ADDR_W), .INIT_ADDR(INIT_ADDR)
    ) dut (
        .clk(clk), .rst(rst),
        .fs_send(fs_send), .fd_send(fd_send), .send_btype(send_btype),
        .send_status(send_status), .retry_cnt(retry_cnt),
        .fs_read(fs_read), .fd_read(fd_read), .read_btype(read_btype),
        .data_idx(data_idx),
        .fs_tx(fs_tx), .fd_tx(fd_tx), .tx_btype(tx_btype),
        .fs_rx(fs_rx), .fd_rx(fd_rx), .rx_btype(rx_btype),
        .rx_ram_init(rx_ram_init)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int tx_b;
        int init;
        int retry;
        int status;
        int rdb;
    } ev_t;

    ev_t q[$];
    int  checks   = 0;
    int  failures = 0;
    int  m_status = 0;
    int  m_read   = 0;
    int  m_nak    = 0;
    int  plan[$];
    int  ans_delay = -1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic void push_ev(input int k, input int txb, input int init,
                                    input int rt, input int st, input int rdb);
        ev_t e;
        e.kind = k; e.tx_b = txb; e.init = init;
        e.retry = rt; e.status = st; e.rdb = rdb;
        q.push_back(e);
    endfunction

    function automatic void set_plan(input int n, input int a0, input int a1,
                                     input int a2, input int a3);
        plan.delete();
        if (n > 0) plan.push_back(a0);
        if (n > 1) plan.push_back(a1);
        if (n > 2) plan.push_back(a2);
        if (n > 3) plan.push_back(a3);
    endfunction

    function automatic logic sig(input int w);
        case (w)
            0:       return fs_tx;
            1:       return fd_rx;
            2:       return fd_send;
            3:       return fs_read;
            default: return 1'b0;
        endcase
    endfunction

    function automatic string sig_name(input int w);
        case (w)
            0:       return "fs_tx";
            1:       return "fd_rx";
            2:       return "fd_send";
            default: return "fs_read";
        endcase
    endfunction

    // called on a falling edge; returns on a falling edge
    task automatic wait_out(input int w, input logic lvl, input int budget, output bit ok);
        int n = 0;
        while (sig(w) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (sig(w) === lvl);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_%s actual=%b required=%b after %0d cycles",
                     sig_name(w), sig(w), lvl, budget);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_fd_send"},     int'(fd_send), 0);
        check({p, "_fs_read"},     int'(fs_read), 0);
        check({p, "_fs_tx"},       int'(fs_tx), 0);
        check({p, "_fd_rx"},       int'(fd_rx), 0);
        check({p, "_tx_btype"},    int'(tx_btype), 0);
        check({p, "_read_btype"},  int'(read_btype), 0);
        check({p, "_send_status"}, int'(send_status), 0);
        check({p, "_retry_cnt"},   int'(retry_cnt), 0);
        check({p, "_rx_ram_init"}, int'(rx_ram_init), INIT_ADDR);
    endtask

    // One send session. plan[k] is the answer to attempt k+1 (-1: silence).
    task automatic send_txn(input logic [3:0] bt);
        int retry = 1, status = 0, attempt = 0, ans, d, n;
        bit resolved = 0, ok;
        push_ev(K_TX, int'(bt), INIT_ADDR, 1, 0, m_read);
        send_btype = bt;
        fs_send    = 1'b1;
        while (!resolved) begin
            ans = (attempt < plan.size()) ? plan[attempt] : -1;
            attempt++;
            wait_out(0, 1'b1, 20, ok);
            if (!ok) break;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            fd_tx = 1'b1;
            @(negedge clk);
            fd_tx = 1'b0;
            if (ans < 0) begin
                if (retry < MAX_RETRY) begin
                    retry++;
                    push_ev(K_TX, int'(bt), INIT_ADDR, retry, 0, m_read);
                end else begin
                    status = 2; resolved = 1;
                    push_ev(K_DONE, int'(bt), INIT_ADDR, retry, 2, m_read);
                end
                n = 0;
                // a stray fd_tx inside the answer window must not matter
                while (!(fs_tx || fd_send) && n < TIMEOUT + 5) begin
                    fd_tx = (n == 3);
                    @(negedge clk);
                    n++;
                end
                fd_tx = 1'b0;
                check("answer_window_len", n, TIMEOUT);
            end else begin
                d = (ans_delay >= 0) ? ans_delay : $urandom_range(0, TIMEOUT - 1);
                if (ans == 1) begin
                    status = 1; resolved = 1;
                    push_ev(K_DONE, int'(bt), INIT_ADDR, retry, 1, m_read);
                end else if (ans == 3) begin
                    status = 3; resolved = 1;
                    push_ev(K_DONE, int'(bt), INIT_ADDR, retry, 3, m_read);
                end else if (retry < MAX_RETRY) begin
                    retry++;
                    push_ev(K_TX, int'(bt), INIT_ADDR, retry, 0, m_read);
                end else begin
                    status = 2; resolved = 1;
                    push_ev(K_DONE, int'(bt), INIT_ADDR, retry, 2, m_read);
                end
                repeat (d) @(negedge clk);
                rx_btype = 4'(ans);
                fs_rx    = 1'b1;
                wait_out(1, 1'b1, 10, ok);
                fs_rx = 1'b0;
            end
        end
        m_status = status;
        wait_out(2, 1'b1, 20, ok);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        fs_send = 1'b0;
        wait_out(2, 1'b0, 5, ok);
    endtask

    // One received packet with automatic answer.
    task automatic read_txn(input int idx, input int rb);
        int  base, ansv;
        bit  valid, ok;
        valid = (idx < NUM_SLOT);
        base  = valid ? ((idx * SLOT_SIZE) % (1 << ADDR_W)) : INIT_ADDR;
        if (!valid) ansv = 3;
        else if (rb == 15 && m_nak < MAX_RETRY - 1) begin ansv = 2; m_nak++; end
        else begin ansv = 1; m_nak = 0; end
        push_ev(K_TX,   ansv, base, 0, m_status, rb);
        push_ev(K_READ, ansv, base, 0, m_status, rb);
        m_read   = rb;
        data_idx = 4'(idx);
        rx_btype = 4'(rb);
        fs_rx    = 1'b1;
        wait_out(1, 1'b1, 10, ok);
        fs_rx = 1'b0;
        wait_out(0, 1'b1, 10, ok);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        fd_tx = 1'b1;
        @(negedge clk);
        fd_tx = 1'b0;
        wait_out(3, 1'b1, 10, ok);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        fd_read = 1'b1;
        @(negedge clk);
        fd_read = 1'b0;
        wait_out(3, 1'b0, 5, ok);
    endtask

    task automatic take_event(input int k);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=kind%0d required=none", k);
        end else begin
            e = q.pop_front();
            check("ev_kind",        k, e.kind);
            check("ev_tx_btype",    int'(tx_btype), e.tx_b);
            check("ev_rx_ram_init", int'(rx_ram_init), e.init);
            check("ev_retry_cnt",   int'(retry_cnt), e.retry);
            check("ev_send_status", int'(send_status), e.status);
            check("ev_read_btype",  int'(read_btype), e.rdb);
        end
    endtask

    // monitor: every rising fs_tx / fd_send / fs_read is matched to the queue
    initial begin
        bit p_tx, p_done, p_rd;
        p_tx = 0; p_done = 0; p_rd = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_tx = 0; p_done = 0; p_rd = 0;
            end else begin
                if (fs_tx && !p_tx)     take_event(K_TX);
                if (fd_send && !p_done) take_event(K_DONE);
                if (fs_read && !p_rd)   take_event(K_READ);
                p_tx = fs_tx; p_done = fd_send; p_rd = fs_read;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, v;
        bit ok;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        set_plan(1, 1, 0, 0, 0);   ans_delay = 10;  send_txn(4'h5);
        ans_delay = -1;
        set_plan(4, 2, 2, 2, 1);   send_txn(4'h9);
        set_plan(4, -1, -1, -1, -1); send_txn(4'h3);
        set_plan(1, 3, 0, 0, 0);   send_txn(4'h4);
        set_plan(4, 15, 2, 7, 2);  send_txn(4'h6);
        set_plan(2, 2, 1, 0, 0);   ans_delay = TIMEOUT - 1; send_txn(4'hA);
        ans_delay = -1;
        set_plan(3, -1, 2, 1, 0);  send_txn(4'hC);

        read_txn(3, 5);
        read_txn(9, 6);
        read_txn(5, 7);
        read_txn(6, 8);
        read_txn(0, 15);
        read_txn(1, 15);
        read_txn(2, 15);
        read_txn(4, 15);
        read_txn(1, 15);
        read_txn(12, 15);
        read_txn(2, 15);

        // reset in the middle of the answer window
        push_ev(K_TX, 7, INIT_ADDR, 1, 0, m_read);
        send_btype = 4'h7;
        fs_send    = 1'b1;
        wait_out(0, 1'b1, 20, ok);
        fd_tx = 1'b1;
        @(negedge clk);
        fd_tx = 1'b0;
        repeat (3) @(negedge clk);
        rst     = 1'b1;
        fs_send = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        check_reset("rst_hold");
        rst = 1'b0;
        q.delete();
        m_status = 0; m_read = 0; m_nak = 0;
        @(negedge clk);

        read_txn(1, 15);
        read_txn(2, 15);
        read_txn(3, 15);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                plan.delete();
                for (int k = 0; k < MAX_RETRY; k++) begin
                    r = $urandom_range(0, 9);
                    if (r <= 3)      v = 1;
                    else if (r == 4) v = 3;
                    else if (r <= 6) v = 2;
                    else if (r == 7) v = ($urandom_range(0, 1) == 1) ? 15 : int'($urandom_range(4, 14));
                    else             v = -1;
                    plan.push_back(v);
                end
                send_txn(4'($urandom_range(0, 15)));
            end else begin
                r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 15))
                                                : int'($urandom_range(0, 5));
                v = ($urandom_range(0, 9) < 4) ? 15 : int'($urandom_range(0, 15));
                read_txn(r, v);
            end
        end

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
